// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Lookup is combinational from the table; training writes take effect after the clock edge.
module branch_target_buffer #(
  parameter int unsigned ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        predicted_taken,
  output logic [31:0] predicted_pc,
  output logic        lookup_hit,
  input  logic        update_en,
  input  logic [31:0] update_pc,
  input  logic [31:0] update_target,
  input  logic        update_taken
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX_W;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         ctr_q    [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic [1:0]       upd_ctr;
  logic [1:0]       ctr_next;
  logic             unused_pc_bits;

  assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

  // Lookup path: byte offset bits are ignored, index then tag above it.
  always_comb begin
    fetch_idx       = fetch_pc[IDX_W+1:2];
    fetch_tag       = fetch_pc[31:IDX_W+2];
    lookup_hit      = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    predicted_taken = lookup_hit && ctr_q[fetch_idx][1];
    predicted_pc    = predicted_taken ? target_q[fetch_idx] : fetch_pc + 32'd4;
  end

  // Saturating counter step for the entry addressed by the update port.
  always_comb begin
    upd_idx  = update_pc[IDX_W+1:2];
    upd_tag  = update_pc[31:IDX_W+2];
    upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr  = ctr_q[upd_idx];
    ctr_next = upd_ctr;
    if (update_taken) begin
      if (upd_ctr != CTR_ST) ctr_next = upd_ctr + 2'd1;
    end else begin
      if (upd_ctr != CTR_SNT) ctr_next = upd_ctr - 2'd1;
    end
  end

  // Table state; reset wins over a coincident update.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < int'(ENTRIES); i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (update_en) begin
      if (upd_hit) begin
        ctr_q[upd_idx] <= ctr_next;
        if (update_taken) target_q[upd_idx] <= update_target;
      end else if (update_taken) begin
        // Only taken outcomes allocate, so never-taken branches stay out.
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= update_target;
        ctr_q[upd_idx]    <= CTR_WT;
      end
    end
  end

endmodule

// File: doc/branch_target_buffer.md
# branch_target_buffer

Fetch-stage branch predictor sitting directly upstream of the execute-stage jump/branch resolution logic. Each cycle it looks up the fetch PC and supplies a predicted-taken flag and next-PC to the fetch stage. The flag travels down the pipeline as the execute stage's `predictedTaken`. When the execute stage resolves a jump or branch, it writes back the branch PC, the resolved target and the actual outcome to train the table.

## Interface
- `ENTRIES`, 16, number of direct-mapped entries; power of two, minimum 2.
- `IDX_W`, log2(ENTRIES), index width; derived, not overridden.

- `clk` in 1: clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `fetch_pc` in 32: PC currently being fetched.
- `predicted_taken` out 1: lookup hit and entry counter predicts taken.
- `predicted_pc` out 32: stored target if `predicted_taken`, else `fetch_pc + 4`.
- `lookup_hit` out 1: valid entry with matching tag, regardless of counter.
- `update_en` in 1: execute stage holds a jump or branch (its `update_btb`).
- `update_pc` in 32: PC of the resolved instruction.
- `update_target` in 32: resolved target address (`jump_addr`).
- `update_taken` in 1: actual outcome; 1 for every jal/jalr and for taken branches.

## Operation
- Address split:
  - index = pc[IDX_W+1:2]
  - tag = pc[31:IDX_W+2]
  - pc[1:0] ignored.
- Entry contents: valid (1), tag (30-IDX_W), target (32), ctr (2).
- Counter states: 00 SNT, 01 WNT, 10 WT, 11 ST. Predict taken when ctr[1]=1.
- Lookup is purely combinational from the table registers:
  - hit = valid & tag match.
  - `predicted_taken` = hit & ctr[1].
- Update, applied only when `update_en`=1, to the entry at update index:
  - Hit and taken: ctr saturating increment (ST stays ST); target := `update_target`.
  - Hit and not taken: ctr saturating decrement (SNT stays SNT); target and valid unchanged.
  - Miss and taken: allocate by overwriting any existing entry (valid:=1, tag, target:=`update_target`, ctr:=10 WT).
  - Miss and not taken: no change. Never-taken branches do not pollute the table.
- `update_en`=0: table unchanged.
- Target arithmetic: `fetch_pc + 4` is 32-bit modular; 0xFFFFFFFC wraps to 0x00000000.

## Timing
- Lookup latency: 0 cycles; outputs follow `fetch_pc` combinationally.
- Update latency: a write at edge N is visible to lookups from cycle N onward, i.e. after that edge.
- Update and lookup on the same index in the same cycle: lookup returns pre-update contents. No write-to-read bypass.
- Only one update port; no update conflicts possible.
- Reset:
  - All valid bits clear to 0, ctr clears to 01 (WNT), target clears to 0.
  - Outputs after reset: `predicted_taken`=0, `lookup_hit`=0, `predicted_pc`=`fetch_pc`+4.
  - `rst` has priority over `update_en` in the same cycle; the update is dropped.
  - Reset mid-operation discards all training.
- No X propagation permitted: every entry field is reset.

## Test plan
- Reset, then `fetch_pc`=0x100 -> `lookup_hit`=0, `predicted_taken`=0, `predicted_pc`=0x104.
- Update pc=0x100, target=0x200, taken=1; next cycle `fetch_pc`=0x100 -> hit=1, taken=1, `predicted_pc`=0x200. Repeat the taken update -> ctr=11; a further taken update keeps it at 11.
- From ST, two not-taken updates to 0x100 -> WT then WNT. Lookup gives hit=1, taken=0, `predicted_pc`=0x104. Two more not-taken -> SNT, saturated.
- Alias with ENTRIES=16: train 0x100 taken to target 0x200, then update 0x140 (same index, different tag) taken to target 0x300.
  - Lookup 0x100 -> miss, `predicted_pc` 0x104.
  - Lookup 0x140 -> taken, 0x300.
  - A not-taken update to 0x180 on a miss leaves the 0x140 entry intact.
- Same-cycle conflict: `fetch_pc`=0x100 while updating 0x100 taken on an empty table -> that cycle predicted_taken=0; next cycle predicted_taken=1.
- `rst` asserted together with a taken update after training -> all lookups miss the next cycle. `fetch_pc`=0xFFFFFFFC on a miss -> `predicted_pc`=0x00000000.
